// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and constants for the decoder address-sweep sequencer.
package decoder_scan_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned NUM_LINES = 32;
    localparam int unsigned DWELL_MIN = 1;

endpackage

// File: rtl/decoder_scan_ctrl_dec.sv
// Combinational 5-to-32 decoder: a 3-to-8 line decode replicated across
// four banks, with the upper two select bits choosing the bank.
module decoder5to32 (
    input  logic [4:0]  sel,
    output logic [31:0] y
);

    logic [7:0] line;
    logic [3:0] bank;

    always_comb begin
        line           = '0;
        line[sel[2:0]] = 1'b1;
        bank           = '0;
        bank[sel[4:3]] = 1'b1;
        y              = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            y[b*8 +: 8] = bank[b] ? line : 8'h00;
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sweeps the decoder select from a latched first to last address (wrapping
// 31->0), holding each one-hot enable for a latched dwell count.
module decoder_scan_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    first,
    input  logic [ADDR_W-1:0]    last,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot,
    output logic                 active,
    output logic                 done
);

    import decoder_scan_ctrl_pkg::*;

    scan_state_t        state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] reload_q;
    logic [ADDR_W-1:0]  last_q;
    logic [DWELL_W-1:0] dwell_reload;
    logic [31:0]        dec_out;

    // A dwell of zero behaves as the minimum, so the reload value saturates at 0.
    always_comb begin
        dwell_reload = '0;
        if (dwell >= DWELL_W'(DWELL_MIN)) begin
            dwell_reload = dwell - DWELL_W'(DWELL_MIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            active   <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            reload_q <= '0;
            last_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        last_q   <= last;
                        reload_q <= dwell_reload;
                        cnt      <= dwell_reload;
                        addr     <= first;
                        active   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (addr == last_q) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        addr <= addr + 1'b1;
                        cnt  <= reload_q;
                    end
                end
                default: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    decoder5to32 u_dec (
        .sel (addr),
        .y   (dec_out)
    );

    assign onehot = dec_out & {(2**ADDR_W){active}};

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed self-checking bench for decoder_scan_ctrl.
module tb_decoder_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [7:0]  dwell;
    logic        abort;
    logic [4:0]  addr;
    logic [31:0] onehot;
    logic        active;
    logic        done;

    int n_checks;
    int n_fail;

    decoder_scan_ctrl #(.ADDR_W(5), .DWELL_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .first  (first),
        .last   (last),
        .dwell  (dwell),
        .abort  (abort),
        .addr   (addr),
        .onehot (onehot),
        .active (active),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        first = '0; last = '0; dwell = '0;
        #2;
        n_checks++;
        if ({addr, active, done, onehot} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_state: addr=%0d active=%b done=%b onehot=%h, required all zero", addr, active, done, onehot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (active !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: active=%b done=%b, required 0 0", active, done);
        end
    endtask

    task automatic test_full_sweep();
        logic [31:0] exp;
        first = 5'd0; last = 5'd31; dwell = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp = 32'h1 << i;
            n_checks++;
            if (addr !== 5'(i) || onehot !== exp || active !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL full_sweep_step%0d: addr=%0d onehot=%h active=%b done=%b, required addr=%0d onehot=%h active=1 done=0",
                         i, addr, onehot, active, done, i, exp);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || active !== 1'b0 || onehot !== 32'h0) begin
            n_fail++;
            $display("FAIL full_sweep_done: done=%b active=%b onehot=%h, required done=1 active=0 onehot=0", done, active, onehot);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL full_sweep_after: done=%b active=%b, required 0 0", done, active);
        end
    endtask

    task automatic test_wrap_dwell();
        logic [4:0]  seq [8];
        logic [31:0] exp;
        seq = '{5'd30, 5'd30, 5'd31, 5'd31, 5'd0, 5'd0, 5'd1, 5'd1};
        first = 5'd30; last = 5'd1; dwell = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = 32'h1 << seq[i];
            n_checks++;
            if (addr !== seq[i] || onehot !== exp || active !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_step%0d: addr=%0d onehot=%h active=%b, required addr=%0d onehot=%h active=1",
                         i, addr, onehot, active, seq[i], exp);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b active=%b, required 1 0", done, active);
        end
        tick();
    endtask

    task automatic test_dwell_zero();
        first = 5'd7; last = 5'd7; dwell = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (addr !== 5'd7 || onehot !== 32'h0000_0080 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL dwell0_run: addr=%0d onehot=%h active=%b, required 7 00000080 1", addr, onehot, active);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || active !== 1'b0 || onehot !== 32'h0 || addr !== 5'd7) begin
            n_fail++;
            $display("FAIL dwell0_done: done=%b active=%b onehot=%h addr=%0d, required 1 0 0 7", done, active, onehot, addr);
        end
        tick();
    endtask

    task automatic test_abort();
        bit found;
        bit saw_done;
        found = 1'b0;
        first = 5'd0; last = 5'd31; dwell = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (addr == 5'd5) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_reach_addr5: addr=%0d after 40 cycles, required 5", addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (active !== 1'b0 || onehot !== 32'h0 || done !== 1'b0 || addr !== 5'd5) begin
            n_fail++;
            $display("FAIL abort_stop: active=%b onehot=%h done=%b addr=%0d, required 0 0 0 5", active, onehot, done, addr);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done || active !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: saw_done=%b active=%b, required 0 0", saw_done, active);
        end
        first = 5'd9; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (active !== 1'b0 || addr !== 5'd5) begin
            n_fail++;
            $display("FAIL abort_blocks_start: active=%b addr=%0d, required 0 5", active, addr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        first = 5'd3; last = 5'd5; dwell = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (addr !== 5'd3 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first: addr=%0d active=%b, required 3 1", addr, active);
        end
        first = 5'd20; last = 5'd25; dwell = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (addr !== 5'd4 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: addr=%0d active=%b, required 4 1", addr, active);
        end
        tick();
        n_checks++;
        if (addr !== 5'd5 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_last_step: addr=%0d active=%b, required 5 1", addr, active);
        end
        first = 5'd10; last = 5'd11; dwell = 8'd1; start = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b1 || active !== 1'b0 || addr !== 5'd5) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b active=%b addr=%0d, required 1 0 5", done, active, addr);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (active !== 1'b1 || addr !== 5'd10 || done !== 1'b0 || onehot !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL b2b_second_start: active=%b addr=%0d done=%b onehot=%h, required 1 10 0 00000400", active, addr, done, onehot);
        end
        tick();
        n_checks++;
        if (addr !== 5'd11 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_step: addr=%0d active=%b, required 11 1", addr, active);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_done: done=%b active=%b, required 1 0", done, active);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        first = 5'd0; last = 5'd31; dwell = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_checks++;
        if (addr !== 5'd12 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: addr=%0d active=%b, required 12 1", addr, active);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({addr, active, done, onehot} !== 39'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: addr=%0d active=%b done=%b onehot=%h, required all zero", addr, active, done, onehot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (active !== 1'b0 || done !== 1'b0 || addr !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: active=%b done=%b addr=%0d, required 0 0 0", active, done, addr);
        end
        first = 5'd2; last = 5'd3; dwell = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (addr !== 5'd2 || active !== 1'b1 || onehot !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL rst_mid_restart: addr=%0d active=%b onehot=%h, required 2 1 00000004", addr, active, onehot);
        end
        tick();
        tick();
        n_checks++;
        if (done !== 1'b1 || active !== 1'b0 || addr !== 5'd3) begin
            n_fail++;
            $display("FAIL rst_mid_restart_done: done=%b active=%b addr=%0d, required 1 0 3", done, active, addr);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_sweep();
        test_wrap_dwell();
        test_dwell_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequencer that drives the 5-to-32 decoder datapath through a programmable address sweep. On a start request it latches a first/last address and a per-address dwell count, then steps the decoder select from first to last, wrapping 31→0 if needed. Each one-hot enable is held for the dwell period. It sits between the control/register layer and the decoder, and owns the decoder select lines exclusively while busy.

## Interface
Parameters:
- ADDR_W, 5, decoder select width; fixed at 5 for the 32-line decoder.
- DWELL_W, 8, width of the dwell-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
- start  input  1  sweep request, sampled only in IDLE.
- first  input  ADDR_W  first address, latched on accepted start.
- last  input  ADDR_W  last address, latched on accepted start.
- dwell  input  DWELL_W  cycles per address, latched on accepted start; 0 is treated as 1.
- abort  input  1  terminate sweep; sampled every cycle.
- addr  output  ADDR_W  current decoder select (registered).
- onehot  output  2**ADDR_W  decoded enable; equals 1<<addr when active, else all zero.
- active  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the last address completes normally.

## Operation
- States: IDLE, RUN.
- IDLE: active=0, onehot=0, addr holds its last value.
  - start=1 and abort=0 → latch first/last/dwell, set addr=first, load dwell counter with max(dwell,1)-1, go to RUN.
- RUN: each cycle, if dwell counter ≠ 0, decrement it.
  - Else if addr==last → go to IDLE and pulse done.
  - Else addr = addr+1 mod 32, and reload the counter with max(latched dwell,1)-1.
- Wrap: if last < first, the sweep passes 31→0. If first==last, exactly one address is visited.
- Address count visited is ((last-first) mod 32)+1. Total RUN cycles = that count × max(dwell,1).
- abort=1 in RUN → next cycle IDLE, onehot=0, no done pulse. abort has priority over start in the same cycle.
- start while in RUN is ignored; it is not queued.
- Input changes to first/last/dwell during RUN have no effect.

## Timing
- Reset values: addr=0, active=0, onehot=0, done=0, state=IDLE, counter=0.
- Reset asserted mid-sweep forces all of the above immediately (asynchronous), with no done pulse.
- Start latency: start sampled high at edge k gives active=1, addr=first, onehot valid after edge k.
- onehot is combinational from registered addr and active only; it has no combinational path from inputs.
- done is asserted in the cycle immediately after the final RUN cycle, concurrent with active=0.
- A new start is accepted in the same cycle that done is high, giving back-to-back sweeps with a one-cycle IDLE gap.

## Structure
- Shared package:
  - state enum (IDLE, RUN)
  - ADDR_W and NUM_LINES=32 constants
  - helper constant for the dwell minimum (1)
- Sub-module: decoder5to32, a combinational 5-to-32 decoder built from the team's existing 3-to-8 decoder plus a 2-bit bank select. It is instantiated once, and its output is ANDed with active.
- Controller RTL: state register, addr register, dwell counter, latched last/dwell registers.

## Test plan
- Full sweep: first=0, last=31, dwell=1 → addr 0..31 on consecutive cycles, onehot=1<<addr each cycle, done pulse in cycle 33 after start, active low afterwards.
- Wrap with dwell: first=30, last=1, dwell=2 → addr sequence 30,30,31,31,0,0,1,1, then done; onehot bit 31 followed directly by bit 0.
- Dwell zero and single address: first=last=7, dwell=0 → one RUN cycle with onehot=0x00000080, then done.
- Abort: sweep 0→31, dwell=4, abort at addr=5 → onehot=0 next cycle, done never pulses; start together with abort in IDLE is not accepted.
- Busy start and back-to-back: start pulsed during RUN has no effect on addr/last; start held high at done → second sweep begins one cycle later with the newly latched first.
- Reset mid-run: rst_n low during addr=12 → outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE and a start behaves normally.
